// File: rtl/dot_plot_scheduler_if.sv
// Point request bundle for the two requesters (cursor = req0, plotter = req1).
// master drives points and sees ready; slave is the scheduler side.
interface dot_plot_scheduler_if;
  logic       req0_valid;
  logic [8:0] req0_x;
  logic [8:0] req0_y;
  logic       req0_ready;
  logic       req1_valid;
  logic [8:0] req1_x;
  logic [8:0] req1_y;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/dot_plot_scheduler.sv
// Plot-point table shared by cursor and plotter; shadow table copied to active table in vblank.
// Define DOT_SCHED_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module dot_plot_scheduler #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ORIGIN_X = 170,
  parameter int unsigned ORIGIN_Y = 141
) (
  input  logic                       clk25MHz,
  input  logic                       reset_n,
  input  logic                       vblank,
  input  logic                       clear,
  dot_plot_scheduler_if.slave        req,
  input  logic [9:0]                 counter_x,
  input  logic [9:0]                 counter_y,
  output logic                       hit,
  output logic                       hit_src,
  output logic [4:0]                 count,
  output logic                       full,
  output logic                       busy
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0]  OX = 10'(ORIGIN_X);
  localparam logic [9:0]  OY = 10'(ORIGIN_Y);

  typedef enum logic {IDLE, COPY} state_t;

  typedef struct packed {
    logic       src;
    logic [8:0] x;
    logic [8:0] y;
  } entry_t;

  state_t          state, state_n;
  entry_t          shadow [DEPTH];
  entry_t          active [DEPTH];
  logic            vblank_q;
  logic [4:0]      active_count;
  logic [4:0]      snap_count;
  logic [IW-1:0]   copy_idx;
  logic            clear_pend;
  logic            rdy0, rdy1, xfer;
  logic            hit_c, src_c;
  entry_t          wr_entry;
`ifdef DOT_SCHED_RR_EN
  logic            last_grant;
`endif

  assign full  = (count == 5'(DEPTH));
  assign busy  = (state == COPY);
  assign xfer  = rdy0 | rdy1;
  assign wr_entry = rdy1 ? '{src: 1'b1, x: req.req1_x, y: req.req1_y}
                         : '{src: 1'b0, x: req.req0_x, y: req.req0_y};

  // Readys are forced low while reset is held; internal grants need no gating since flops are held.
  assign req.req0_ready = rdy0 & reset_n;
  assign req.req1_ready = rdy1 & reset_n;

  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    case (state)
      IDLE: begin
        if (vblank && !vblank_q) state_n = COPY;
        if (!full && !clear) begin
`ifdef DOT_SCHED_RR_EN
          if (req.req0_valid && req.req1_valid) begin
            rdy0 = last_grant;
            rdy1 = !last_grant;
          end else begin
            rdy0 = req.req0_valid;
            rdy1 = req.req1_valid;
          end
`else
          rdy0 = req.req0_valid;
          rdy1 = req.req1_valid && !req.req0_valid;
`endif
        end
      end
      COPY: begin
        if (&copy_idx) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q     <= 1'b0;
      count        <= '0;
      active_count <= '0;
      snap_count   <= '0;
      copy_idx     <= '0;
      clear_pend   <= 1'b0;
      hit          <= 1'b0;
      hit_src      <= 1'b0;
`ifdef DOT_SCHED_RR_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      vblank_q <= vblank;
      hit      <= hit_c;
      hit_src  <= src_c;
      if (state == IDLE) begin
        copy_idx <= '0;
        if (state_n == COPY) snap_count <= count;
        if (clear)     count <= '0;
        else if (xfer) count <= count + 5'd1;
`ifdef DOT_SCHED_RR_EN
        if (xfer) last_grant <= rdy1;
`endif
      end else begin
        copy_idx <= copy_idx + IW'(1);
        if (clear) clear_pend <= 1'b1;
        // A clear seen anywhere in COPY, including its last cycle, lands on the return to IDLE.
        if (&copy_idx) begin
          active_count <= snap_count;
          clear_pend   <= 1'b0;
          if (clear_pend || clear) count <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (state == IDLE && xfer) shadow[count[IW-1:0]] <= wr_entry;
    if (state == COPY)         active[copy_idx]      <= shadow[copy_idx];
  end

  always_comb begin
    hit_c = 1'b0;
    src_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit_c && (5'(i) < active_count) &&
          (counter_x == OX + {1'b0, active[i].x}) &&
          (counter_y == OY + {1'b0, active[i].y})) begin
        hit_c = 1'b1;
        src_c = active[i].src;
      end
    end
  end

endmodule

// File: doc/dot_plot_scheduler.md
# dot_plot_scheduler

Shares the plot-point table of the 640x480 display between two requesters: the switch-driven cursor and a data plotter. It accepts one point per cycle through a round-robin arbiter into a shadow table. During vertical blanking it copies the shadow table into an active table. Each pixel clock it tells the pattern generator whether the current beam position hits an active point. It sits between the 25 MHz timing counters and the pixel colour logic.

## Interface
Parameters:
- DEPTH, 8: number of point entries; power of two, 2..16.
- ORIGIN_X, 170: x offset of the plot area, added to every point x.
- ORIGIN_Y, 141: y offset of the plot area, added to every point y.

Ports:
- clk25MHz  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vblank  in  1  level; high while counter_y is outside the visible rows.
- clear  in  1  one-cycle pulse; empties the shadow table.
- req0_valid  in  1  cursor requester has a point.
- req0_x  in  9  cursor point x.
- req0_y  in  9  cursor point y.
- req0_ready  out  1  cursor point accepted this cycle.
- req1_valid  in  1  plotter requester has a point.
- req1_x  in  9  plotter point x.
- req1_y  in  9  plotter point y.
- req1_ready  out  1  plotter point accepted this cycle.
- counter_x  in  10  current horizontal counter.
- counter_y  in  10  current vertical counter.
- hit  out  1  registered; high when the counters matched an active point.
- hit_src  out  1  registered; requester of the matching entry (0 or 1).
- count  out  5  number of valid shadow entries.
- full  out  1  high when count == DEPTH.
- busy  out  1  high while in COPY.

## Operation
- State machine:
  - IDLE: accepts requests.
  - COPY: transfers shadow entries to the active table.
  - A rising edge of vblank, detected against a registered copy, moves IDLE→COPY.
  - COPY lasts exactly DEPTH cycles; it copies entry i in cycle i.
  - On the last COPY cycle, active_count <= count snapshot taken on COPY entry; state returns to IDLE.
- Arbitration, IDLE only, when !full and !clear:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
  - last_grant updates only on an actual transfer.
  - Transfer = valid && ready.
  - readyN is combinational from valid, state, full, clear and last_grant.
  - At most one ready is high per cycle.
- Write: entry[count] <= {src, x, y}; count <= count+1.
- Full: both readys low and requests stall. No entry is overwritten.
- clear in IDLE: count <= 0 next cycle. The same-cycle request is not accepted (ready low).
- clear during COPY: latched and applied on the COPY→IDLE transition.
- The shadow table persists across frames; only clear or reset empties it.
- Lookup: entry i matches when i < active_count, counter_x == ORIGIN_X + x, and counter_y == ORIGIN_Y + y.
  - Sums are 10-bit from zero-extended 9-bit inputs; no overflow (max 170+511 = 681).
  - hit_src takes the lowest-index match.
- Reset: state IDLE, count 0, active_count 0, last_grant 1 (req0 wins first tie), vblank edge register 0. Outputs: hit 0, hit_src 0, readys 0, full 0, busy 0.
- Reset mid-COPY aborts the copy; active table is empty afterwards.

## Timing
- Accepted point visible in count: 1 cycle after the transfer.
- Accepted point visible in the lookup: after the next complete COPY.
- COPY start: 1 cycle after vblank rises.
- busy: high for DEPTH cycles.
- hit/hit_src: valid 1 cycle after the counters, so the pattern generator delays its colour path by 1.
- vblank held high through COPY: no re-trigger until it falls and rises again.

## Configuration
- DOT_SCHED_RR_EN defined: round-robin arbitration as above.
- Undefined: fixed priority; req0 always wins when both are valid, and last_grant is unused.
- Full, clear and COPY behaviour are identical in both builds.

## Test plan
- Reset: reset_n low mid-stream → hit 0, count 0, busy 0, req0_ready 0; the first tie after release grants req0.
- Tie (RR build), both valid continuously for 4 cycles → grants alternate 0,1,0,1; count 4. Fixed build → 0,0,0,0.
- Full, DEPTH=8: 8 accepts → full 1; a 9th req0_valid is held 3 cycles with ready 0 → count stays 8. Then clear → count 0 next cycle and ready returns.
- Point (x=10, y=5) from req1, then a vblank rise → busy high for 8 cycles. At counter_x=180, counter_y=146: hit=1 and hit_src=1 one cycle later. Before the copy, the same counters give hit=0.
- clear pulsed in COPY cycle 3 → count unchanged until COPY ends, then 0. The active table still holds the copied points.
- Two entries at the same position, from req0 then req1 → hit_src=0 (lowest index wins).
